load_store_unit: RTL

Bus master between the core's memory stage and the address decoder and device read-data path.
- Accepts one load/store request at a time.
- Converts the byte address to the decoder's 14-bit word address.
- Drives write-enable/read-enable, byte enables and write data for one cycle.
- Waits the device read latency, then selects device read data using the decoder's out_sel.
- Aligns and sign/zero-extends loads and returns a single-cycle response.
- Flags misaligned accesses and illegal funct3 codes.

---
 rtl/rv32i_lsu_pkg.sv | 44 ++++
 rtl/lsu_load_align.sv | 27 ++
 rtl/load_store_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rv32i_lsu_pkg.sv
// rtl/rv32i_lsu_pkg.sv - shared types, funct3 codes and access-check helpers for the load/store unit
// Contents: F3_* size/sign codes, OUT_SEL_NONE, lsu_state_t, req_error(), lane_mask().
package rv32i_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Decoder select value that maps to no device; reads return zero.
  localparam logic [1:0] OUT_SEL_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  // Illegal size/sign code or an address not aligned to the access size.
  function automatic logic req_error(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic illegal;
    logic misaligned;
    if (we) illegal = (funct3 > F3_W);
    else    illegal = !(funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misaligned = ((funct3[1:0] == 2'd1) && addr_lo[0]) ||
                 ((funct3[1:0] == 2'd2) && (addr_lo != 2'd0));
    return illegal || misaligned;
  endfunction

  // Byte lanes touched by an access; funct3[1:0] encodes the size for both loads and stores.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic [3:0] base;
    case (funct3[1:0])
      2'd0:    base = 4'b0001;
      2'd1:    base = 4'b0011;
      default: base = 4'b1111;
    endcase
    return base << addr_lo;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the addressed byte/half of a read word and extends it to 32 bits
// Ports: word (device read word), addr_lo (byte offset), funct3 (size/sign code),
//        data (extended result, zero for codes that are not loads).
module lsu_load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data = shifted;
      F3_BU:   data = {24'd0, shifted[7:0]};
      F3_HU:   data = {16'd0, shifted[15:0]};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store bus master between the core and the address decoder
// Ports: clk, rst (async, active low); req_* core request (valid/ready handshake);
//        rsp_* one-cycle response; bus_* single-cycle strobe to the decoder;
//        bus_out_sel decoder select for bus_addr; rdata0..2 device read data.
module load_store_unit
  import rv32i_lsu_pkg::*;
#(
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_wen,
  output logic              bus_ren,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic [1:0]        bus_out_sel,
  input  logic [31:0]       rdata0,
  input  logic [31:0]       rdata1,
  input  logic [31:0]       rdata2
);

  // WAIT counts down from READ_LATENCY-1; zero marks the cycle device data is valid.
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  lsu_state_t  state, state_next;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_addr_lo;
  logic [1:0]  lat_sel;
  logic [1:0]  wait_cnt;
  logic        accept;
  logic        acc_err;
  logic [31:0] wdata_rep;
  logic [31:0] dev_word;
  logic [31:0] load_data;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign acc_err   = req_error(req_we, req_funct3, req_addr[1:0]);

  always_comb begin
    case (req_funct3[1:0])
      2'd0:    wdata_rep = {4{req_wdata[7:0]}};
      2'd1:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  always_comb begin
    case (lat_sel)
      2'd0:    dev_word = rdata0;
      2'd1:    dev_word = rdata1;
      2'd2:    dev_word = rdata2;
      default: dev_word = 32'd0;
    endcase
  end

  lsu_load_align u_align (
    .word    (dev_word),
    .addr_lo (lat_addr_lo),
    .funct3  (lat_funct3),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = acc_err ? RESP : ISSUE;
      ISSUE:   state_next = lat_we ? RESP : WAIT;
      WAIT:    if (wait_cnt == 2'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_addr    <= '0;
      bus_wen     <= 1'b0;
      bus_ren     <= 1'b0;
      bus_be      <= 4'd0;
      bus_wdata   <= 32'd0;
      rsp_rdata   <= 32'd0;
      rsp_err     <= 1'b0;
      lat_we      <= 1'b0;
      lat_funct3  <= 3'd0;
      lat_addr_lo <= 2'd0;
      lat_sel     <= 2'd0;
      wait_cnt    <= 2'd0;
    end else begin
      // Bus outputs are one-cycle pulses: cleared every cycle unless a request is launched.
      bus_addr  <= '0;
      bus_wen   <= 1'b0;
      bus_ren   <= 1'b0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      case (state)
        IDLE: if (accept) begin
          lat_we      <= req_we;
          lat_funct3  <= req_funct3;
          lat_addr_lo <= req_addr[1:0];
          if (acc_err) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= 32'd0;
          end else begin
            bus_addr  <= req_addr[ADDR_W+1:2];
            bus_be    <= lane_mask(req_funct3, req_addr[1:0]);
            bus_wen   <= req_we;
            bus_ren   <= !req_we;
            bus_wdata <= req_we ? wdata_rep : 32'd0;
          end
        end
        ISSUE: begin
          // Decoder select is combinational on bus_addr, so it is only valid now.
          lat_sel  <= bus_out_sel;
          wait_cnt <= WAIT_INIT;
          if (lat_we) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 2'd1;
          if (wait_cnt == 2'd0) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
